cmp_serial2b: RTL and testbench

//   Bit-serial magnitude comparator for WIDTH-bit unsigned operands.

---
 rtl/cmp_serial2b.sv | 177 +++++++++++++++++
 tb/tb_cmp_serial2b.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_serial2b.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_serial2b
//  Purpose  : Bit-serial unsigned magnitude comparator. Walks the operands
//             one 2-bit digit per clock, most significant digit first, and
//             latches the first digit position where they differ. After
//             DIGITS RUN cycles the eq/lt/gt flags are registered and a
//             one-cycle done pulse is produced.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             start_i  - compare request, sampled only while idle
//             a_i/b_i  - operands, captured on the accepting edge
//             busy_o   - compare in progress
//             done_o   - one-cycle pulse, flags just updated
//             eq_o/lt_o/gt_o - result of the last completed compare
//  Revision : 1.0  initial release
// ============================================================================
module cmp_serial2b #(
   parameter int WIDTH = 8            // operand width, even and >= 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             eq_o,
   output logic             lt_o,
   output logic             gt_o
);

   localparam int DIGITS = WIDTH / 2;
   localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dec_q, dec_d;   // a differing digit has been seen
   logic             dlt_q, dlt_d;   // at that digit, a < b
   logic             done_q, done_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;
   logic             gt_q, gt_d;

   // ------------------------------------------------------------------------
   // Digit slice: current top digit of each shift register
   // ------------------------------------------------------------------------
   logic [1:0]       w_da;
   logic [1:0]       w_db;
   logic             w_dec_next;
   logic             w_dlt_next;
   logic [WIDTH-1:0] w_sa_shl;
   logic [WIDTH-1:0] w_sb_shl;

   assign w_da = sa_q[WIDTH-1:WIDTH-2];
   assign w_db = sb_q[WIDTH-1:WIDTH-2];

   // Once decided, the decision is frozen; less significant digits cannot
   // overturn a difference found at a more significant position.
   assign w_dec_next = dec_q | (w_da != w_db);
   assign w_dlt_next = dec_q ? dlt_q : (w_da < w_db);

   // A 2-bit operand has nothing below its only digit, so the shifted value
   // is simply zero; the wide form would otherwise need an empty slice.
   generate
      if (WIDTH > 2) begin : g_shift_wide
         assign w_sa_shl = {sa_q[WIDTH-3:0], 2'b00};
         assign w_sb_shl = {sb_q[WIDTH-3:0], 2'b00};
      end else begin : g_shift_narrow
         assign w_sa_shl = '0;
         assign w_sb_shl = '0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      dlt_d   = dlt_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      lt_d    = lt_q;
      gt_d    = gt_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               sa_d    = a_i;
               sb_d    = b_i;
               cnt_d   = CNT_LOAD;
               dec_d   = 1'b0;
               dlt_d   = 1'b0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            dec_d = w_dec_next;
            dlt_d = w_dlt_next;
            sa_d  = w_sa_shl;
            sb_d  = w_sb_shl;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ZERO) begin
               // Last digit: fold this cycle's digit into the result directly
               // so the flags land on the same edge as done.
               eq_d    = ~w_dec_next;
               lt_d    = w_dec_next & w_dlt_next;
               gt_d    = w_dec_next & ~w_dlt_next;
               done_d  = 1'b1;
               cnt_d   = CNT_ZERO;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         dlt_q   <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         dlt_q   <= dlt_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy_o = (state_q == S_RUN);
   assign done_o = done_q;
   assign eq_o   = eq_q;
   assign lt_o   = lt_q;
   assign gt_o   = gt_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_serial2b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_serial2b
//  Purpose  : Directed self-checking bench for cmp_serial2b. An 8-bit
//             instance covers latency, decision position, ignored starts,
//             mid-compare reset and back-to-back operation; a 4-bit
//             instance is swept over every operand pair.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmp_serial2b;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, eq, lt, gt;

   logic       start4;
   logic [3:0] a4, b4;
   logic       busy4, done4, eq4, lt4, gt4;

   int n_err;
   int n_chk;
   logic [2:0] last;   // expected {eq,lt,gt} of the last 8-bit completion

   cmp_serial2b #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
      .busy_o(busy), .done_o(done), .eq_o(eq), .lt_o(lt), .gt_o(gt)
   );

   cmp_serial2b #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
      .busy_o(busy4), .done_o(done4), .eq_o(eq4), .lt_o(lt4), .gt_o(gt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 8-bit compare: accept, then expect done exactly four edges later.
   task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] exp);
      int  n;
      bit  found;
      a = va; b = vb; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~va; b = ~vb;          // later operand changes must not matter
      chk({tag, "_busy0"}, busy, 1);
      found = 0;
      n = 0;
      while (!found && n < 12) begin
         tick();
         n++;
         if (done) found = 1;
         else chk({tag, "_hold"}, {eq, lt, gt}, last);
      end
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_flags"}, {eq, lt, gt}, exp);
      chk({tag, "_busyend"}, busy, 0);
      last = exp;
      tick();
      chk({tag, "_pulse"}, done, 0);
   endtask

   task automatic run4(input logic [3:0] va, input logic [3:0] vb);
      int  n;
      bit  found;
      logic [2:0] exp;
      exp = (va == vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
      a4 = va; b4 = vb; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      found = 0;
      n = 0;
      while (!found && n < 8) begin
         tick();
         n++;
         if (done4) found = 1;
      end
      if (n != 2 || {eq4, lt4, gt4} != exp)
         chk($sformatf("w4_%h_%h", va, vb), {n[7:0], 1'b0, eq4, lt4, gt4},
             {8'd2, 1'b0, exp});
      else
         n_chk++;
   endtask

   initial begin
      int ndone;
      logic [2:0] seen;
      logic [7:0] pa [4];
      logic [7:0] pb [4];
      logic [2:0] pe [4];

      n_err = 0; n_chk = 0; last = 3'b000;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_outs", {busy, done, eq, lt, gt}, 5'b0);
      chk("rst_outs4", {busy4, done4, eq4, lt4, gt4}, 5'b0);
      rst_n = 1'b1;
      tick();
      chk("idle_outs", {busy, done, eq, lt, gt}, 5'b0);

      // Equal operands, then differences at the MSB and LSB digit
      run8("eq_a5", 8'hA5, 8'hA5, 3'b100);
      run8("gt_msb", 8'h80, 8'h7F, 3'b001);
      run8("lt_lsb", 8'h34, 8'h35, 3'b010);
      run8("lt_00ff", 8'h00, 8'hFF, 3'b010);
      run8("gt_c080", 8'hC0, 8'h80, 3'b001);
      run8("eq_ff", 8'hFF, 8'hFF, 3'b100);
      run8("lt_1221", 8'h12, 8'h21, 3'b010);

      // Start raised mid-compare is ignored
      a = 8'h10; b = 8'h20; start = 1'b1;
      tick();                                   // E0
      start = 1'b0; a = 8'h00; b = 8'h00;
      tick(); tick();                           // E1, E2
      start = 1'b1; a = 8'hFF; b = 8'h00;
      tick();                                   // E3
      start = 1'b0;
      ndone = 0; seen = 3'b000;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) begin
            ndone++;
            seen = {eq, lt, gt};
         end
      end
      chk("ign_ndone", ndone, 1);
      chk("ign_flags", seen, 3'b010);
      chk("ign_idle", busy, 0);
      last = 3'b010;

      // Reset pulse between E2 and E3 aborts the compare
      a = 8'hF0; b = 8'h0F; start = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      tick(); tick();                           // E1, E2
      #2 rst_n = 1'b0;
      #1 chk("abort_outs", {busy, done, eq, lt, gt}, 5'b0);
      #1 rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("abort_nodone", ndone, 0);
      chk("abort_flags", {busy, eq, lt, gt}, 4'b0);
      last = 3'b000;
      run8("post_rst", 8'hF0, 8'h0F, 3'b001);

      // start held high: each accept happens in the done cycle, so results
      // arrive every four RUN cycles plus the accepting idle cycle.
      pa[0] = 8'h55; pb[0] = 8'h56; pe[0] = 3'b010;
      pa[1] = 8'h9C; pb[1] = 8'h9C; pe[1] = 3'b100;
      pa[2] = 8'hE1; pb[2] = 8'hD1; pe[2] = 3'b001;
      pa[3] = 8'h02; pb[3] = 8'h03; pe[3] = 3'b010;
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = pa[k]; b = pb[k];
         tick();                                // accepting edge
         chk($sformatf("b2b%0d_busy", k), busy, 1);
         a = ~pa[k]; b = 8'h5A;
         for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4)
               chk($sformatf("b2b%0d_hold%0d", k, i), {done, eq, lt, gt}, {1'b0, last});
            else
               chk($sformatf("b2b%0d_res", k), {done, eq, lt, gt}, {1'b1, pe[k]});
         end
         last = pe[k];
      end
      start = 1'b0;
      tick();
      chk("b2b_end", {busy, done}, 2'b00);

      // Exhaustive 4-bit sweep
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run4(4'(i), 4'(j));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
